// File: rtl/turn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : turn_sequencer
// Purpose  : Turn controller for the tic-tac-toe datapath. Owns the board
//            register and alternates moves, player first. Each proposed move
//            is shown to the external wrong-move checker through a one-hot
//            enable. The move is then committed or rejected and re-requested.
//            After every commit the board is scored for a win or a draw.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock           in   1  rising-edge clock
//   reset_n         in   1  asynchronous active-low reset
//   start           in   1  begin a new game (honoured in IDLE / DONE)
//   player_move     in   4  player cell code 1..9
//   player_valid    in   1  player_move valid
//   player_ready    out  1  player move accepted this cycle
//   computer_move   in   4  computer cell code 1..9
//   computer_valid  in   1  computer_move valid
//   computer_ready  out  1  computer move accepted this cycle
//   wrong_move      in   1  combinational verdict from the external checker
//   p_enable        out  9  one-hot player cell strobe (bit k-1 = cell k)
//   c_enable        out  9  one-hot computer cell strobe
//   pos1..pos9      out  2  cell contents: 00 empty, 01 player, 10 computer
//   illegal         out  1  pulse during a rejecting CHECK cycle
//   move_count      out  4  committed moves 0..9
//   winner          out  2  00 none, 01 player, 10 computer, 11 draw
//   game_over       out  1  high while in DONE
// ============================================================================
module turn_sequencer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] player_move,
    input  logic       player_valid,
    output logic       player_ready,
    input  logic [3:0] computer_move,
    input  logic       computer_valid,
    output logic       computer_ready,
    input  logic       wrong_move,
    output logic [8:0] p_enable,
    output logic [8:0] c_enable,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic       illegal,
    output logic [3:0] move_count,
    output logic [1:0] winner,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_P_WAIT  = 3'd1,
        S_P_CHECK = 3'd2,
        S_P_EVAL  = 3'd3,
        S_C_WAIT  = 3'd4,
        S_C_CHECK = 3'd5,
        S_C_EVAL  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam logic [1:0] c_WIN_NONE     = 2'b00;
    localparam logic [1:0] c_WIN_PLAYER   = 2'b01;
    localparam logic [1:0] c_WIN_COMPUTER = 2'b10;
    localparam logic [1:0] c_WIN_DRAW     = 2'b11;
    localparam logic [3:0] c_FULL_BOARD   = 4'd9;

    state_t     state_q, state_d;
    // The board is held as two occupancy masks; bit k-1 stands for cell k.
    logic [8:0] pmask_q, pmask_d;
    logic [8:0] cmask_q, cmask_d;
    logic [3:0] move_q,  move_d;
    logic [3:0] count_q, count_d;
    logic [1:0] winner_q, winner_d;

    logic [8:0] w_cell;
    logic       w_occupied;
    logic       w_reject;

    // Codes outside 1..9 decode to no cell at all, which forces a reject.
    function automatic logic [8:0] decode_cell(input logic [3:0] code);
        logic [8:0] onehot;
        onehot = 9'd0;
        if (code >= 4'd1 && code <= 4'd9) begin
            onehot = 9'd1 << (code - 4'd1);
        end
        return onehot;
    endfunction

    // Rows, columns and both diagonals.
    function automatic logic has_line(input logic [8:0] m);
        return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
               (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
    endfunction

    // Occupancy is checked here as well, so a misbehaving external checker
    // can never cause a cell to be overwritten.
    assign w_cell     = decode_cell(move_q);
    assign w_occupied = |(w_cell & (pmask_q | cmask_q));
    assign w_reject   = wrong_move | (w_cell == 9'd0) | w_occupied;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            pmask_q  <= 9'd0;
            cmask_q  <= 9'd0;
            move_q   <= 4'd0;
            count_q  <= 4'd0;
            winner_q <= c_WIN_NONE;
        end else begin
            state_q  <= state_d;
            pmask_q  <= pmask_d;
            cmask_q  <= cmask_d;
            move_q   <= move_d;
            count_q  <= count_d;
            winner_q <= winner_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pmask_d  = pmask_q;
        cmask_d  = cmask_q;
        move_d   = move_q;
        count_d  = count_q;
        winner_d = winner_q;
        p_enable = 9'd0;
        c_enable = 9'd0;
        illegal  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pmask_d  = 9'd0;
                    cmask_d  = 9'd0;
                    count_d  = 4'd0;
                    winner_d = c_WIN_NONE;
                    state_d  = S_P_WAIT;
                end
            end
            S_P_WAIT: begin
                if (player_valid) begin
                    move_d  = player_move;
                    state_d = S_P_CHECK;
                end
            end
            S_P_CHECK: begin
                p_enable = w_cell;
                if (w_reject) begin
                    illegal = 1'b1;
                    state_d = S_P_WAIT;
                end else begin
                    pmask_d = pmask_q | w_cell;
                    count_d = count_q + 4'd1;
                    state_d = S_P_EVAL;
                end
            end
            S_P_EVAL: begin
                if (has_line(pmask_q)) begin
                    winner_d = c_WIN_PLAYER;
                    state_d  = S_DONE;
                end else if (count_q == c_FULL_BOARD) begin
                    winner_d = c_WIN_DRAW;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_C_WAIT;
                end
            end
            S_C_WAIT: begin
                if (computer_valid) begin
                    move_d  = computer_move;
                    state_d = S_C_CHECK;
                end
            end
            S_C_CHECK: begin
                c_enable = w_cell;
                if (w_reject) begin
                    illegal = 1'b1;
                    state_d = S_C_WAIT;
                end else begin
                    cmask_d = cmask_q | w_cell;
                    count_d = count_q + 4'd1;
                    state_d = S_C_EVAL;
                end
            end
            S_C_EVAL: begin
                // The draw branch is kept for symmetry even though a
                // player-first game always fills the board on a player move.
                if (has_line(cmask_q)) begin
                    winner_d = c_WIN_COMPUTER;
                    state_d  = S_DONE;
                end else if (count_q == c_FULL_BOARD) begin
                    winner_d = c_WIN_DRAW;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_P_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign player_ready   = (state_q == S_P_WAIT);
    assign computer_ready = (state_q == S_C_WAIT);
    assign game_over      = (state_q == S_DONE);
    assign move_count     = count_q;
    assign winner         = winner_q;

    assign pos1 = {cmask_q[0], pmask_q[0]};
    assign pos2 = {cmask_q[1], pmask_q[1]};
    assign pos3 = {cmask_q[2], pmask_q[2]};
    assign pos4 = {cmask_q[3], pmask_q[3]};
    assign pos5 = {cmask_q[4], pmask_q[4]};
    assign pos6 = {cmask_q[5], pmask_q[5]};
    assign pos7 = {cmask_q[6], pmask_q[6]};
    assign pos8 = {cmask_q[7], pmask_q[7]};
    assign pos9 = {cmask_q[8], pmask_q[8]};

endmodule
`default_nettype wire

// File: doc/turn_sequencer.md
# turn_sequencer

Turn controller for the tic-tac-toe datapath. Owns the nine-cell board register and alternates player and computer moves, player first. For each move it drives a one-hot `p_enable`/`c_enable` to the external wrong-move checker, then commits the move, or rejects it and re-requests it. After each commit it evaluates win and draw and ends the game.

## Interface
Parameters: none.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin new game; honoured only in IDLE and DONE.
- `player_move` in 4: player cell code, 1..9.
- `player_valid` in 1: `player_move` valid.
- `player_ready` out 1: sequencer accepts a player move this cycle.
- `computer_move` in 4: computer cell code, 1..9.
- `computer_valid` in 1: `computer_move` valid.
- `computer_ready` out 1: sequencer accepts a computer move this cycle.
- `wrong_move` in 1: combinational result from the checker for the current enables and board.
- `p_enable` out 9: one-hot player cell strobe; bit k-1 means cell k.
- `c_enable` out 9: one-hot computer cell strobe.
- `pos1`..`pos9` out 2 each: board cells; 00 empty, 01 player, 10 computer.
- `illegal` out 1: one-cycle pulse when a move is rejected.
- `move_count` out 4: committed moves, 0..9.
- `winner` out 2: 00 none, 01 player, 10 computer, 11 draw.
- `game_over` out 1: high in DONE.

## Operation
States are IDLE, P_WAIT, P_CHECK, P_EVAL, C_WAIT, C_CHECK, C_EVAL and DONE.

- **IDLE**
  - On `start`: clear board, `move_count`=0, `winner`=00, then go to P_WAIT.
- **P_WAIT**
  - `player_ready`=1.
  - On `player_valid`: latch `player_move` into the move register, then go to P_CHECK.
- **P_CHECK**
  - `p_enable` = decode(move register); all other enables are 0.
  - reject = `wrong_move` OR code outside 1..9. A code outside 1..9 decodes to all-zero enables.
  - On reject: `illegal` pulses this cycle, board unchanged, go back to P_WAIT.
  - Otherwise: write 01 into the cell at the clock edge, increment `move_count`, go to P_EVAL.
- **P_EVAL**
  - Check the registered board for three 01 cells in a line. The 8 lines are 123, 456, 789, 147, 258, 369, 159 and 357.
  - Win: `winner`=01, go to DONE.
  - No win and `move_count`=9: `winner`=11, go to DONE.
  - Otherwise: go to C_WAIT.
- **C_WAIT, C_CHECK, C_EVAL**
  - Same as the player states, using `computer_ready`, `c_enable`, cell value 10 and `winner`=10.
  - The draw test still applies in C_EVAL. With player-first play it is unreachable after a computer move.
- **DONE**
  - `game_over`=1; board and `winner` hold.
  - On `start`: clear board, counters and `winner`, then go to P_WAIT.
- **General rules**
  - `start` is ignored in every state other than IDLE and DONE.
  - Valid inputs are ignored whenever the matching ready is low.
  - `p_enable` and `c_enable` are never both nonzero. Each is all-zero outside its CHECK state.
  - A move is never written to a non-empty cell, even if `wrong_move` misbehaves. Cell occupancy is also checked internally and rolled into reject.

## Timing
- **Reset**: state IDLE, all `pos`=00, `move_count`=0, `winner`=00, `game_over`=0, `illegal`=0, both readies 0, both enables 0.
- **Per-move latency** is 3 cycles:
  - accept edge in WAIT;
  - CHECK cycle, with enables driven and `wrong_move` sampled at the end of the cycle; the board updates at that edge;
  - EVAL cycle.
  - The opposing ready rises in the cycle after EVAL.
- **Ready/valid**: ready is a registered state decode. An accepted move is held internally, so upstream may change the bus on the next cycle.
- **`illegal`** is high only during the rejecting CHECK cycle. Ready reasserts 1 cycle later.
- **Outputs**: `winner` and `game_over` are registered and valid from the first DONE cycle.
- **Reset mid-game**: `reset_n` low clears everything asynchronously. No partial move is retained.

## Test plan
- **Reset**: hold `reset_n`=0 mid-game, then release -> all `pos`=00, state IDLE, `player_ready`=0 until `start`.
- **Player row win**:
  - stimulus: `start`; P1, C4, P2, C5, P3;
  - required: `pos1`-`pos3`=01 and `pos4`/`pos5`=10;
  - then `winner`=01 and `game_over`=1 one cycle after the third P_CHECK commit;
  - `move_count`=5; `computer_ready` never rises again.
- **Reoccupation reject**:
  - stimulus: P5, then computer proposes 5 while the checker asserts `wrong_move`;
  - required: `c_enable`=9'b000010000 for one cycle, `illegal` pulses, `pos5` stays 01, `computer_ready` returns after 1 cycle;
  - then C1 is accepted.
- **Out-of-range codes**: `player_move`=0 and then 12 -> both rejected with `illegal`, `p_enable`=0 in CHECK, board unchanged.
- **Draw**:
  - stimulus: P1 C2 P3 C5 P4 C6 P8 C7 P9;
  - required: `move_count`=9, `winner`=11, `game_over`=1;
  - then `start` in DONE -> board cleared, `player_ready`=1 after 1 cycle.
- **Enable exclusivity**: random legal games -> assert `p_enable` and `c_enable` are each at most one-hot and never active together.
